// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed four-digit seven-segment scan controller.
// Frame-aligned double-buffered display value, per-digit blanking and whole-display blink.
module seven_seg_scan_ctrl #(
    parameter int DWELL        = 50000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  blank_mask,
    input  logic        blink_en,
    output logic [3:0]  nibble,
    output logic [3:0]  an,
    output logic [1:0]  digit_sel,
    output logic        frame_tick,
    output logic        pend
);

    localparam int             CNT_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
    localparam logic [7:0]     FRM_MAX = 8'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             tick_q, tick_d;
    logic [15:0]      active_q, active_d;
    logic [15:0]      pending_q, pending_d;
    logic             pend_q, pend_d;
    logic [7:0]       frm_q, frm_d;
    logic             phase_q, phase_d;

    logic dwell_end;
    logic frame_wrap;
    logic phase_on;

    assign dwell_end  = (cnt_q == CNT_MAX);
    assign frame_wrap = dwell_end && (sel_q == 2'd3);
    // Disabling blink must light the display in the same cycle, not one later.
    assign phase_on   = phase_q || !blink_en;

    always_comb begin
        cnt_d     = dwell_end ? '0 : cnt_q + CNT_W'(1);
        sel_d     = dwell_end ? sel_q + 2'd1 : sel_q;
        tick_d    = frame_wrap;
        active_d  = active_q;
        pending_d = pending_q;
        pend_d    = pend_q;
        frm_d     = frm_q;
        phase_d   = phase_q;

        // Old pending is promoted before a coincident load replaces it.
        if (frame_wrap && pend_q) begin
            active_d = pending_q;
            pend_d   = 1'b0;
        end
        if (load) begin
            pending_d = value;
            pend_d    = 1'b1;
        end

        if (!blink_en) begin
            frm_d   = 8'd0;
            phase_d = 1'b1;
        end else if (frame_wrap) begin
            if (frm_q == FRM_MAX) begin
                frm_d   = 8'd0;
                phase_d = !phase_q;
            end else begin
                frm_d = frm_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            sel_q     <= 2'd0;
            tick_q    <= 1'b0;
            active_q  <= 16'h0000;
            pending_q <= 16'h0000;
            pend_q    <= 1'b0;
            frm_q     <= 8'd0;
            phase_q   <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            tick_q    <= tick_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            frm_q     <= frm_d;
            phase_q   <= phase_d;
        end
    end

    always_comb begin
        an = 4'b1111;
        if (!blank_mask[sel_q] && phase_on) begin
            an = ~(4'b0001 << sel_q);
        end
    end

    assign nibble     = active_q[{sel_q, 2'b00} +: 4];
    assign digit_sel  = sel_q;
    assign frame_tick = tick_q;
    assign pend       = pend_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with DWELL=4, BLINK_FRAMES=2: directed table,
// hand-written corner sequences and randomized traffic against a cycle-count model.
module tb_seven_seg_scan_ctrl;

    localparam int DW = 4;
    localparam int BF = 2;
    localparam int FRAME = 4 * DW;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic        blink_en = 1'b0;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic [1:0]  digit_sel;
    logic        frame_tick;
    logic        pend;

    int checks = 0;
    int errors = 0;

    seven_seg_scan_ctrl #(.DWELL(DW), .BLINK_FRAMES(BF)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .blink_en   (blink_en),
        .nibble     (nibble),
        .an         (an),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick),
        .pend       (pend)
    );

    always #5 clk = ~clk;

    // Model: position in the scan is just cycles since reset; blink phase is
    // the number of enabled frame wraps divided into BF-sized halves.
    int          m_t = 0;
    logic [15:0] m_active = 16'h0;
    logic [15:0] m_pending = 16'h0;
    logic        m_pend = 1'b0;
    int          m_wraps = 0;

    task automatic model_edge();
        bit wrap;
        if (rst) begin
            m_t = 0; m_active = 16'h0; m_pending = 16'h0; m_pend = 1'b0; m_wraps = 0;
        end else begin
            wrap = ((m_t % FRAME) == FRAME - 1);
            if (wrap && m_pend) begin
                m_active = m_pending;
                m_pend = 1'b0;
            end
            if (load) begin
                m_pending = value;
                m_pend = 1'b1;
            end
            if (!blink_en) m_wraps = 0;
            else if (wrap) m_wraps++;
            m_t++;
        end
    endtask

    function automatic logic [11:0] model_vec();
        int d;
        logic [3:0] e_an;
        logic       e_tick;
        logic       off;
        d = (m_t / DW) % 4;
        off = blink_en && (((m_wraps / BF) % 2) != 0);
        e_an = (blank_mask[d] || off) ? 4'b1111 : ~(4'b0001 << d);
        e_tick = (m_t != 0) && ((m_t % FRAME) == 0);
        return {m_active[d*4 +: 4], e_an, 2'(d), e_tick, m_pend};
    endfunction

    function automatic logic [11:0] dut_vec();
        return {nibble, an, digit_sel, frame_tick, pend};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h ({nibble,an,sel,tick,pend}) t=%0d", name, act, exp, m_t);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step_chk(input string name);
        step();
        check(name, dut_vec(), model_vec());
    endtask

    task automatic adv_to(input int phase, input string name);
        for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != phase; k++) step_chk(name);
    endtask

    typedef struct {
        logic        rst;
        logic        load;
        logic [15:0] value;
        logic [3:0]  blank;
        int          n;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 4'h0, 1,  {4'h0, 4'b1110, 2'd0, 1'b0, 1'b0}};
        tbl[1]  = '{1'b0, 1'b1, 16'h4321, 4'h0, 1,  {4'h0, 4'b1110, 2'd0, 1'b0, 1'b1}};
        tbl[2]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 3,  {4'h0, 4'b1101, 2'd1, 1'b0, 1'b1}};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 12, {4'h1, 4'b1110, 2'd0, 1'b1, 1'b0}};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 1,  {4'h1, 4'b1110, 2'd0, 1'b0, 1'b0}};
        tbl[5]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 3,  {4'h2, 4'b1101, 2'd1, 1'b0, 1'b0}};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 4,  {4'h3, 4'b1011, 2'd2, 1'b0, 1'b0}};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 4'h4, 1,  {4'h3, 4'b1111, 2'd2, 1'b0, 1'b0}};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 4'h0, 3,  {4'h4, 4'b0111, 2'd3, 1'b0, 1'b0}};
        tbl[9]  = '{1'b0, 1'b1, 16'hABCD, 4'h0, 1,  {4'h4, 4'b0111, 2'd3, 1'b0, 1'b1}};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 4'h0, 3,  {4'hD, 4'b1110, 2'd0, 1'b1, 1'b0}};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 4'h0, 4,  {4'hC, 4'b1101, 2'd1, 1'b0, 1'b0}};

        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst;
            load = tbl[i].load;
            value = tbl[i].value;
            blank_mask = tbl[i].blank;
            for (int c = 0; c < tbl[i].n; c++) begin
                step();
                load = 1'b0;
                rst = 1'b0;
            end
            check($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
        end

        // Collision: load on the frame-wrap cycle shows the older pending first.
        adv_to(5, "pre_collision");
        load = 1'b1; value = 16'h1111;
        step_chk("load_1111");
        load = 1'b0;
        adv_to(FRAME - 1, "to_wrap");
        load = 1'b1; value = 16'h2222;
        step();
        load = 1'b0;
        check("collision_first", dut_vec(), {4'h1, 4'b1110, 2'd0, 1'b1, 1'b1});
        for (int c = 0; c < FRAME - 1; c++) step_chk("collision_frame");
        step();
        check("collision_second", dut_vec(), {4'h2, 4'b1110, 2'd0, 1'b1, 1'b0});

        // Blink: two frames lit, two dark; dropping enable relights immediately.
        blink_en = 1'b1;
        for (int c = 0; c < 2 * FRAME + 6; c++) step_chk("blink_run");
        check("blink_off_an", {8'h0, an}, {8'h0, 4'b1111});
        blink_en = 1'b0;
        #1;
        check("blink_drop_an", {8'h0, an}, {8'h0, 4'b1101});
        check("blink_drop_model", dut_vec(), model_vec());
        blink_en = 1'b1;
        for (int c = 0; c < 6 * FRAME; c++) step_chk("blink_long");
        blink_en = 1'b0;
        step_chk("blink_disabled");

        // Reset during digit 2 with a pending value.
        adv_to(1, "pre_reset");
        load = 1'b1; value = 16'h5A5A;
        step_chk("load_5a5a");
        load = 1'b0;
        adv_to(9, "to_digit2");
        rst = 1'b1;
        load = 1'b1; value = 16'h7777;
        step();
        rst = 1'b0; load = 1'b0;
        check("reset_mid", dut_vec(), {4'h0, 4'b1110, 2'd0, 1'b0, 1'b0});
        for (int c = 0; c < DW; c++) step_chk("post_reset");
        check("post_reset_sel", {10'h0, digit_sel}, 12'd1);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            load = ($urandom_range(0, 9) == 0);
            value = 16'($urandom);
            if ($urandom_range(0, 39) == 0) blank_mask = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 199) == 0) blink_en = !blink_en;
            step_chk("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter DWELL, default 50000: clocks each digit is driven; legal range 2..2^20.
REQ-002 Parameter BLINK_FRAMES, default 125: full scan frames per blink half-period; legal range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 load  input  1  one-cycle strobe; captures value into pending buffer.
REQ-006 value  input  16  four BCD/hex nibbles; digit d = value[4d+3:4d], digit 0 rightmost.
REQ-007 blank_mask  input  4  bit d = 1 forces digit d dark.
REQ-008 blink_en  input  1  1 = whole display blinks at frame-derived rate.
REQ-009 nibble  output  4  code of current digit, {x3,x2,x1,x0} order, feeds the shared seven-segment decoder.
REQ-010 an  output  4  digit enables, active-low, one-hot-low or all-high.
REQ-011 digit_sel  output  2  index of currently driven digit.
REQ-012 frame_tick  output  1  one-cycle pulse at frame start.
REQ-013 pend  output  1  1 = pending value not yet applied to display.

Function
REQ-014 Dwell counter SHALL count 0..DWELL-1 and wrap to 0; digit_sel SHALL advance by 1 (3 wraps to 0) on the cycle the counter is at DWELL-1.
REQ-015 Frame wrap event = dwell counter at DWELL-1 and digit_sel = 3; frame_tick SHALL be 1 in the cycle after that edge (first cycle of digit 0), else 0.
REQ-016 Display SHALL double-buffer: load captures value into pending register and sets pend next cycle; active register SHALL change only on the frame wrap event.
REQ-017 On frame wrap event with pend = 1: active <= pending, pend <= 0; with pend = 0: active unchanged.
REQ-018 load coincident with frame wrap: existing pending (if pend = 1) copied to active, then new value captured into pending, pend = 1 next cycle; new value shown from the following frame.
REQ-019 load while pend = 1: pending overwritten, last load wins, pend stays 1.
REQ-020 nibble SHALL equal active[4*digit_sel+3 : 4*digit_sel] combinationally from registered state.
REQ-021 an[digit_sel] SHALL be 0 and all other bits 1, unless blank_mask[digit_sel] = 1 or blink phase = off, in which case an = 4'b1111.
REQ-022 Blink: frame counter increments on each frame wrap event; at BLINK_FRAMES-1 it wraps to 0 and blink phase toggles.
REQ-023 blink_en = 0: frame counter held at 0, blink phase forced on in the same cycle; on re-enable counting restarts from 0 with phase on.
REQ-024 nibble and digit_sel SHALL keep scanning while blanked or blink-off; only an is suppressed.

Reset
REQ-025 rst = 1 at a clock edge SHALL set dwell counter 0, digit_sel 0, active 16'h0000, pending 16'h0000, pend 0, frame counter 0, blink phase on; rst dominates load.
REQ-026 Post-reset outputs: nibble 4'h0, digit_sel 0, frame_tick 0, pend 0, an = 4'b1110 (4'b1111 if blank_mask[0] = 1).
REQ-027 Reset mid-dwell or mid-frame SHALL discard pending data and restart scanning at digit 0 next cycle.

Verification (DWELL = 4, BLINK_FRAMES = 2)
REQ-028 Scan: reset release, load 16'h4321, wait one frame wrap -> per frame digit_sel 0,1,2,3 each 4 cycles; nibble 1,2,3,4; an 1110,1101,1011,0111; frame_tick one cycle per 16.
REQ-029 Tearing: load 16'hABCD mid-frame while showing 16'h4321 -> remaining digits of current frame still 3,4; pend = 1; after wrap nibble A..D sequence D,C,B,A, pend = 0.
REQ-030 Collision: load 16'h1111 then load 16'h2222 on the frame wrap cycle -> next frame shows 1111, pend = 1, following frame shows 2222.
REQ-031 Blank/blink: blank_mask 4'b0100 -> an = 1111 during digit 2 only; blink_en = 1 -> an all-high for frames 3-4, 7-8..., nibble scanning unaffected; blink_en = 0 mid-off -> an restored same cycle.
REQ-032 Reset mid-operation: assert rst during digit 2 with pend = 1 -> next cycle digit_sel 0, nibble 0, pend 0, an 1110, scan resumes from count 0.
